// File: rtl/pipe_passthru_valrdy_if.sv
// Val/rdy handshake bundle for both sides of the passthrough pipeline.
// The pipeline itself connects through the slave modport.
interface pipe_passthru_valrdy_if #(
  parameter int p_nbits = 8
);
  logic               in_val;
  logic               in_rdy;
  logic [p_nbits-1:0] in_;
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] out;

  modport master (
    output in_val, in_, out_rdy,
    input  in_rdy, out_val, out
  );

  modport slave (
    input  in_val, in_, out_rdy,
    output in_rdy, out_val, out
  );
endinterface

// File: rtl/pipe_passthru_valrdy.sv
// Elastic multi-stage passthrough pipeline with val/rdy flow control.
// Words advance whenever the next stage is free, so bubbles collapse and throughput stays at one word per cycle.
module pipe_passthru_valrdy #(
  parameter int p_nbits   = 8,
  parameter int p_nstages = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  pipe_passthru_valrdy_if.slave              pipe,
  output logic [$clog2(p_nstages+1)-1:0]     occupancy
);
  localparam int LAST = p_nstages - 1;

  logic [p_nbits-1:0]   d   [p_nstages];
  logic [p_nbits-1:0]   src [p_nstages];
  logic [p_nstages-1:0] v;
  logic [p_nstages-1:0] adv;
  logic [p_nstages-1:0] load;
  logic                 in_rdy_c;
  logic                 in_xfer;
  logic                 out_xfer;

  // Ready chain runs backwards from the consumer, so each stage knows whether it can move forward.
  always_comb begin
    adv       = '0;
    adv[LAST] = v[LAST] && pipe.out_rdy;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = v[i] && (!v[i+1] || adv[i+1]);
    end
    in_rdy_c = !reset && (!v[0] || adv[0]);
  end

  always_comb begin
    for (int i = 0; i < p_nstages; i++) begin
      src[i] = '0;
    end
    load     = '0;
    in_xfer  = pipe.in_val && in_rdy_c;
    out_xfer = v[LAST] && pipe.out_rdy;
    load[0]  = in_xfer;
    src[0]   = pipe.in_;
    for (int i = 1; i < p_nstages; i++) begin
      load[i] = adv[i-1];
      src[i]  = d[i-1];
    end
  end

  // A stage that is both drained and refilled in the same cycle keeps its valid bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_nstages; i++) begin
        d[i] <= '0;
      end
      v         <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < p_nstages; i++) begin
        if (load[i]) begin
          d[i] <= src[i];
          v[i] <= 1'b1;
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
      if (in_xfer && !out_xfer) begin
        occupancy <= occupancy + 1'b1;
      end else if (out_xfer && !in_xfer) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

  assign pipe.in_rdy  = in_rdy_c;
  assign pipe.out_val = v[LAST];
  assign pipe.out     = d[LAST];
endmodule

// File: tb/tb_pipe_passthru_valrdy.sv
// Self-checking bench: directed scenarios on an 8-bit/2-stage pipe and a random
// run on a 16-bit/4-stage pipe against a queue-based reference model.
module tb_pipe_passthru_valrdy;
  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic [1:0] occ_a;
  logic [2:0] occ_b;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_passthru_valrdy_if #(.p_nbits(8))  if_a ();
  pipe_passthru_valrdy_if #(.p_nbits(16)) if_b ();

  pipe_passthru_valrdy #(.p_nbits(8), .p_nstages(2)) dut_a (
    .clk(clk), .reset(reset_a), .pipe(if_a), .occupancy(occ_a)
  );

  pipe_passthru_valrdy #(.p_nbits(16), .p_nstages(4)) dut_b (
    .clk(clk), .reset(reset_b), .pipe(if_b), .occupancy(occ_b)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_a = 1'b1; if_a.in_val = 1'b0; if_a.in_ = 8'h00; if_a.out_rdy = 1'b1;
    tick();
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_rdy_held got=%b exp=0", if_a.in_rdy); end
    checks++;
    if (if_a.out_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_val got=%b exp=0", if_a.out_val); end
    checks++;
    if (if_a.out !== 8'h00) begin errors++; $display("[TB] FAIL reset_out got=%h exp=00", if_a.out); end
    checks++;
    if (occ_a !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy got=%0d exp=0", occ_a); end
    reset_a = 1'b0;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_in_rdy got=%b exp=1", if_a.in_rdy); end
    tick();
    checks++;
    if (if_a.out_val !== 1'b0 || occ_a !== 2'd0) begin
      errors++; $display("[TB] FAIL idle_state out_val=%b occ=%0d exp out_val=0 occ=0", if_a.out_val, occ_a);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] w [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h22, 8'h44, 8'h88};
    int exp_occ;
    for (int t = 0; t < 10; t++) begin
      if_a.out_rdy = 1'b1;
      if_a.in_val  = (t < 8);
      if_a.in_     = (t < 8) ? w[t] : 8'hEE;
      #1;
      if (t < 8) begin
        checks++;
        if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_rdy t=%0d got=%b exp=1", t, if_a.in_rdy); end
      end
      tick();
      exp_occ = ((t + 1 < 8) ? t + 1 : 8) - ((t - 1 < 0) ? 0 : ((t - 1 > 8) ? 8 : t - 1));
      checks++;
      if (occ_a !== exp_occ[1:0]) begin errors++; $display("[TB] FAIL stream_occupancy t=%0d got=%0d exp=%0d", t, occ_a, exp_occ); end
      checks++;
      if (t >= 1 && t <= 8) begin
        if (if_a.out_val !== 1'b1 || if_a.out !== w[t-1]) begin
          errors++; $display("[TB] FAIL stream_out t=%0d val=%b data=%h exp val=1 data=%h", t, if_a.out_val, if_a.out, w[t-1]);
        end
      end else if (if_a.out_val !== 1'b0) begin
        errors++; $display("[TB] FAIL stream_out_idle t=%0d val=%b exp=0", t, if_a.out_val);
      end
    end
  endtask

  task automatic test_backpressure();
    if_a.out_rdy = 1'b0; if_a.in_val = 1'b1; if_a.in_ = 8'hA5;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_a5 in_rdy=%b exp=1", if_a.in_rdy); end
    tick();
    if_a.in_ = 8'h5A;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_5a in_rdy=%b exp=1", if_a.in_rdy); end
    tick();
    if_a.in_ = 8'hFF;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b0 || occ_a !== 2'd2) begin
      errors++; $display("[TB] FAIL bp_full in_rdy=%b occ=%0d exp in_rdy=0 occ=2", if_a.in_rdy, occ_a);
    end
    tick();
    checks++;
    if (occ_a !== 2'd2 || if_a.out_val !== 1'b1 || if_a.out !== 8'hA5) begin
      errors++; $display("[TB] FAIL bp_stall occ=%0d val=%b data=%h exp occ=2 val=1 data=a5", occ_a, if_a.out_val, if_a.out);
    end
    if_a.out_rdy = 1'b1;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_rdy got=%b exp=1", if_a.in_rdy); end
    tick();
    checks++;
    if (occ_a !== 2'd2 || if_a.out !== 8'h5A) begin
      errors++; $display("[TB] FAIL bp_drain1 occ=%0d data=%h exp occ=2 data=5a", occ_a, if_a.out);
    end
    if_a.in_val = 1'b0;
    tick();
    checks++;
    if (occ_a !== 2'd1 || if_a.out_val !== 1'b1 || if_a.out !== 8'hFF) begin
      errors++; $display("[TB] FAIL bp_drain2 occ=%0d val=%b data=%h exp occ=1 val=1 data=ff", occ_a, if_a.out_val, if_a.out);
    end
    tick();
    checks++;
    if (occ_a !== 2'd0 || if_a.out_val !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_empty occ=%0d val=%b exp occ=0 val=0", occ_a, if_a.out_val);
    end
  endtask

  task automatic test_full_simultaneous();
    if_a.out_rdy = 1'b0; if_a.in_val = 1'b1; if_a.in_ = 8'h10;
    tick();
    if_a.in_ = 8'h20;
    tick();
    checks++;
    if (occ_a !== 2'd2) begin errors++; $display("[TB] FAIL full_fill occ=%0d exp=2", occ_a); end
    if_a.out_rdy = 1'b1; if_a.in_ = 8'h3C;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL full_simul_in_rdy got=%b exp=1", if_a.in_rdy); end
    tick();
    checks++;
    if (occ_a !== 2'd2 || if_a.out !== 8'h20) begin
      errors++; $display("[TB] FAIL full_simul_occ occ=%0d data=%h exp occ=2 data=20", occ_a, if_a.out);
    end
    if_a.in_val = 1'b0;
    tick();
    checks++;
    if (if_a.out_val !== 1'b1 || if_a.out !== 8'h3C || occ_a !== 2'd1) begin
      errors++; $display("[TB] FAIL full_simul_3c val=%b data=%h occ=%0d exp val=1 data=3c occ=1", if_a.out_val, if_a.out, occ_a);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    if_a.out_rdy = 1'b0; if_a.in_val = 1'b1; if_a.in_ = 8'h01;
    tick();
    if_a.in_ = 8'h02;
    tick();
    reset_a = 1'b1; if_a.in_val = 1'b0;
    tick();
    checks++;
    if (if_a.out_val !== 1'b0 || occ_a !== 2'd0 || if_a.out !== 8'h00) begin
      errors++; $display("[TB] FAIL midreset_state val=%b occ=%0d data=%h exp val=0 occ=0 data=00", if_a.out_val, occ_a, if_a.out);
    end
    reset_a = 1'b0; if_a.out_rdy = 1'b1; if_a.in_val = 1'b1; if_a.in_ = 8'h77;
    #1;
    checks++;
    if (if_a.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_rdy got=%b exp=1", if_a.in_rdy); end
    tick();
    if_a.in_val = 1'b0;
    checks++;
    if (if_a.out_val !== 1'b0 || occ_a !== 2'd1) begin
      errors++; $display("[TB] FAIL midreset_latency val=%b occ=%0d exp val=0 occ=1", if_a.out_val, occ_a);
    end
    tick();
    checks++;
    if (if_a.out_val !== 1'b1 || if_a.out !== 8'h77) begin
      errors++; $display("[TB] FAIL midreset_77 val=%b data=%h exp val=1 data=77", if_a.out_val, if_a.out);
    end
    tick();
    checks++;
    if (if_a.out_val !== 1'b0 || occ_a !== 2'd0) begin
      errors++; $display("[TB] FAIL midreset_alone val=%b occ=%0d exp val=0 occ=0", if_a.out_val, occ_a);
    end
  endtask

  // Reference: a word is visible once it heads the queue and has spent nstages-1 edges inside.
  task automatic test_random();
    logic [15:0] q_data [$];
    int          q_time [$];
    int          cyc;
    int          cnt;
    logic        exp_in_rdy;
    logic        exp_out_val;
    logic        in_x;
    logic        out_x;
    cyc = 0;
    cnt = 0;
    reset_b = 1'b1; if_b.in_val = 1'b0; if_b.out_rdy = 1'b0; if_b.in_ = 16'h0;
    tick();
    reset_b = 1'b0;
    for (int t = 0; t < 212; t++) begin
      if (t < 200) begin
        if_b.in_val  = ($urandom_range(0, 3) != 0);
        if_b.out_rdy = ($urandom_range(0, 2) != 0);
      end else begin
        if_b.in_val  = 1'b0;
        if_b.out_rdy = 1'b1;
      end
      if_b.in_ = 16'($urandom);
      #1;
      exp_in_rdy  = (cnt < 4) || if_b.out_rdy;
      exp_out_val = (q_data.size() > 0) && (cyc - q_time[0] >= 3);
      checks++;
      if (if_b.in_rdy !== exp_in_rdy) begin
        errors++; $display("[TB] FAIL rand_in_rdy cyc=%0d got=%b exp=%b", cyc, if_b.in_rdy, exp_in_rdy);
      end
      checks++;
      if (if_b.out_val !== exp_out_val) begin
        errors++; $display("[TB] FAIL rand_out_val cyc=%0d got=%b exp=%b", cyc, if_b.out_val, exp_out_val);
      end
      checks++;
      if (occ_b !== cnt[2:0]) begin
        errors++; $display("[TB] FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", cyc, occ_b, cnt);
      end
      if (exp_out_val) begin
        checks++;
        if (if_b.out !== q_data[0]) begin
          errors++; $display("[TB] FAIL rand_out_data cyc=%0d got=%h exp=%h", cyc, if_b.out, q_data[0]);
        end
      end
      in_x  = if_b.in_val && exp_in_rdy;
      out_x = exp_out_val && if_b.out_rdy;
      tick();
      cyc++;
      if (out_x) begin
        void'(q_data.pop_front());
        void'(q_time.pop_front());
        cnt--;
      end
      if (in_x) begin
        q_data.push_back(if_b.in_);
        q_time.push_back(cyc);
        cnt++;
      end
    end
    checks++;
    if (q_data.size() != 0 || occ_b !== 3'd0) begin
      errors++; $display("[TB] FAIL rand_drained left=%0d occ=%0d exp 0", q_data.size(), occ_b);
    end
  endtask

  initial begin
    if_a.in_val = 1'b0; if_a.in_ = '0; if_a.out_rdy = 1'b1;
    if_b.in_val = 1'b0; if_b.in_ = '0; if_b.out_rdy = 1'b1;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_simultaneous();
    test_reset_mid_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
